// File: rtl/sub32_pkg.sv
// Shared constants and types for the sequential 4x32 saturating subtractor.
package sub32_pkg;
  localparam int LANE_W = 32;
  localparam int LANES  = 4;

  localparam logic [LANE_W-1:0] S_MAX = 32'h7FFF_FFFF;
  localparam logic [LANE_W-1:0] S_MIN = 32'h8000_0000;
  localparam logic [LANE_W-1:0] U_MIN = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef logic [1:0] lane_idx_t;
  typedef logic [LANES-1:0][LANE_W-1:0] word_t;
endpackage

// File: rtl/sub32_seq_if.sv
// Operand/result handshake bundle for sub32_seq; SUB32_SAT_FLAG_EN adds sat_flag.
interface sub32_seq_if;
  import sub32_pkg::*;
  logic       in_valid;
  logic       in_ready;
  word_t      src0;
  word_t      src1;
  logic       sign_s0;
  logic       sign_s1;
  logic       out_valid;
  logic       out_ready;
  word_t      dst;
`ifdef SUB32_SAT_FLAG_EN
  logic [LANES-1:0] sat_flag;

  modport master (output in_valid, src0, src1, sign_s0, sign_s1, out_ready,
                  input  in_ready, out_valid, dst, sat_flag);
  modport slave  (input  in_valid, src0, src1, sign_s0, sign_s1, out_ready,
                  output in_ready, out_valid, dst, sat_flag);
`else
  modport master (output in_valid, src0, src1, sign_s0, sign_s1, out_ready,
                  input  in_ready, out_valid, dst);
  modport slave  (input  in_valid, src0, src1, sign_s0, sign_s1, out_ready,
                  output in_ready, out_valid, dst);
`endif
endinterface

// File: rtl/sub32_lane.sv
// One 32-bit saturating subtract lane; signed mode if either operand is signed.
module sub32_lane
  import sub32_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sign_a,
  input  logic              sign_b,
  output logic [LANE_W-1:0] res,
  output logic              sat
);
  // 34 bits hold any mix of signed/unsigned 32-bit operands and their difference
  localparam logic signed [33:0] L_MAX = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] L_MIN = 34'sh3_8000_0000;

  logic signed [33:0] w_a, w_b, w_diff;
  logic               w_signed;

  assign w_a      = sign_a ? {{2{a[LANE_W-1]}}, a} : {2'b00, a};
  assign w_b      = sign_b ? {{2{b[LANE_W-1]}}, b} : {2'b00, b};
  assign w_diff   = w_a - w_b;
  assign w_signed = sign_a | sign_b;

  always_comb begin
    res = w_diff[LANE_W-1:0];
    sat = 1'b0;
    if (w_signed) begin
      if (w_diff > L_MAX) begin
        res = S_MAX;
        sat = 1'b1;
      end else if (w_diff < L_MIN) begin
        res = S_MIN;
        sat = 1'b1;
      end
    end else if (w_diff < 0) begin
      res = U_MIN;
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/sub32_seq.sv
// Sequential 4-lane saturating subtractor: one shared lane, one lane per cycle.
// Optional SUB32_SAT_FLAG_EN exposes per-lane saturation flags.
module sub32_seq
  import sub32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sub32_seq_if.slave  bus
);
  state_e           r_state, w_next;
  lane_idx_t        r_cnt;
  word_t            r_src0, r_src1, r_dst;
  logic             r_sign0, r_sign1;
  logic             w_accept;
  logic [LANE_W-1:0] w_res;
`ifdef SUB32_SAT_FLAG_EN
  logic             w_sat;
  logic [LANES-1:0] r_sat;
`endif

  sub32_lane u_lane (
    .a      (r_src0[r_cnt]),
    .b      (r_src1[r_cnt]),
    .sign_a (r_sign0),
    .sign_b (r_sign1),
    .res    (w_res),
`ifdef SUB32_SAT_FLAG_EN
    .sat    (w_sat)
`else
    .sat    ()
`endif
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: if (bus.in_valid) begin
        w_accept = 1'b1;
        w_next   = CALC;
      end
      CALC: if (r_cnt == lane_idx_t'(LANES-1)) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_src0  <= '0;
      r_src1  <= '0;
      r_sign0 <= 1'b0;
      r_sign1 <= 1'b0;
      r_dst   <= '0;
`ifdef SUB32_SAT_FLAG_EN
      r_sat   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src0  <= bus.src0;
        r_src1  <= bus.src1;
        r_sign0 <= bus.sign_s0;
        r_sign1 <= bus.sign_s1;
        r_cnt   <= '0;
`ifdef SUB32_SAT_FLAG_EN
        r_sat   <= '0;
`endif
      end else if (r_state == CALC) begin
        // counter wraps 3->0 naturally as CALC hands off to DONE
        r_dst[r_cnt] <= w_res;
        r_cnt        <= r_cnt + 1'b1;
`ifdef SUB32_SAT_FLAG_EN
        r_sat[r_cnt] <= w_sat;
`endif
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.dst       = r_dst;
`ifdef SUB32_SAT_FLAG_EN
  assign bus.sat_flag  = r_sat;
`endif
endmodule

// File: doc/sub32_seq.md
Name: sub32_seq

Overview:
- Sequential 4-lane, 32-bit saturating integer subtractor (dst = src0 - src1 per lane). It is the inverse companion of the team's 4x32 combinational saturating adder in the intadd datapath.
- One shared lane subtractor is time-multiplexed across the four lanes, one lane per cycle.
- Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake.
- Sits between the operand-read stage and the writeback buffer.

Parameters:
- LANES, 4, number of 32-bit lanes per 128-bit word (fixed at 4; other values unsupported).
- LANE_W, 32, lane width in bits.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept operands.
- src0  input  128  minuend, lane i = bits [32i+31:32i].
- src1  input  128  subtrahend, same lane layout.
- sign_s0  input  1  1 = src0 lanes are two's complement; 0 = unsigned.
- sign_s1  input  1  1 = src1 lanes are two's complement; 0 = unsigned.
- out_valid  output  1  dst holds a completed result.
- out_ready  input  1  consumer accepts dst.
- dst  output  128  result, same lane layout.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, dst=0, lane counter=0. Any in-flight operation is discarded.
- States and transitions:
  - IDLE: in_ready=1. A handshake (in_valid&in_ready) at an edge captures src0, src1, sign_s0 and sign_s1 into registers, sets lane counter to 0, and moves to CALC.
  - CALC: in_ready=0. Each cycle computes the lane indexed by the counter and writes it into the dst register. Counter runs 0,1,2,3. At the edge that writes lane 3, go to DONE and set out_valid=1.
  - DONE: out_valid=1; dst is stable. When out_valid&out_ready at an edge, clear out_valid and go to IDLE.
- Latency and throughput:
  - out_valid rises 4 edges after the input handshake edge.
  - No input is accepted in CALC or DONE; minimum issue interval is 6 cycles.
  - Input signals changing while not in IDLE have no effect.
- Lane arithmetic:
  - Extend each operand to 34 bits: sign-extend if its sign flag is 1, zero-extend otherwise.
  - diff = a - b, exact in 34 bits.
- Saturation, signed mode (sign_s0 | sign_s1):
  - diff > 0x7FFFFFFF gives 0x7FFFFFFF.
  - diff < -0x80000000 gives 0x80000000.
  - Otherwise dst lane = diff[31:0].
- Saturation, unsigned mode (both flags 0): diff < 0 gives 0x00000000; otherwise dst lane = diff[31:0].
- dst lanes not yet written in CALC hold stale values; only dst in DONE is defined.
- Reset asserted in any state wins over every handshake in the same cycle.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: SUB32_SAT_FLAG_EN.
- When defined:
  - Adds output sat_flag [3:0]; bit i=1 if lane i saturated.
  - Reset value 0; cleared on the input handshake; valid with out_valid.
- When undefined: port absent; saturation still applied, no indication.

Decomposition:
- Package sub32_pkg contains:
  - LANE_W and LANES constants.
  - Clamp constants S_MAX=32'h7FFFFFFF, S_MIN=32'h80000000, U_MIN=32'h0.
  - State enum {IDLE, CALC, DONE}.
  - 2-bit lane-index type.
- One sub-module: sub32_lane, combinational.
  - Inputs: a[31:0], b[31:0], sign_a, sign_b.
  - Outputs: res[31:0] and a saturation bit.
  - Instantiated once and shared across lanes by the FSM.

Test Plan:
- Unsigned basic: all lanes src0=0x00000010, src1=0x00000003, flags 0 -> dst lanes 0x0000000D; out_valid exactly 4 edges after accept.
- Unsigned underflow: lane0 0x00000001-0x00000002, others 5-5 -> lane0 0x00000000, others 0x00000000, sat_flag=4'b0001 with macro.
- Signed overflow: flags 1, lane2 0x7FFFFFFF-0xFFFFFFFF -> 0x7FFFFFFF; lane3 0x80000000-0x00000001 -> 0x80000000; sat_flag=4'b1100.
- Mixed signedness: sign_s0=0, sign_s1=1, 0xFFFFFFFF-0xFFFFFFFF (4294967295-(-1)) -> 0x7FFFFFFF.
- Backpressure: out_ready=0 for 10 cycles in DONE -> dst and out_valid held, in_ready=0; new in_valid ignored; after out_ready=1 for one edge -> IDLE, in_ready=1.
- Reset mid-CALC: rst=1 while counter=2 -> next edge out_valid=0, in_ready=1, dst=0; following operation completes correctly.
